// File: rtl/alu_sweep.sv
// Sequences one operand pair through all eight ALU select codes, letting each
// result settle for SETTLE_CYCLES cycles and handing it downstream as a record.
module alu_sweep #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy_out,
  output logic [7:0]  alu_d0_out,
  output logic [7:0]  alu_d1_out,
  output logic [2:0]  alu_sel_out,
  input  logic [15:0] alu_res_in,
  input  logic        alu_gt_in,
  input  logic        alu_eq_in,
  output logic        rec_valid_out,
  input  logic        rec_ready_in,
  output logic [2:0]  rec_sel_out,
  output logic [15:0] rec_res_out,
  output logic        rec_gt_out,
  output logic        rec_eq_out,
  output logic        done_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] cnt_r;
  logic       settle_end_s;
  logic       xfer_s;
  logic       last_sel_s;

  assign settle_end_s = (state_r == DRIVE) && (cnt_r == CNT_LAST);
  assign xfer_s       = (state_r == EMIT) && rec_ready_in;
  assign last_sel_s   = (alu_sel_out == 3'd7);

  // Next-state decode for the sweep sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_in) state_next_s = DRIVE;
        else          state_next_s = IDLE;
      end
      DRIVE: begin
        if (settle_end_s) state_next_s = EMIT;
        else              state_next_s = DRIVE;
      end
      EMIT: begin
        if (xfer_s) begin
          if (last_sel_s) state_next_s = DONE;
          else            state_next_s = DRIVE;
        end else begin
          state_next_s = EMIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus all datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      busy_out      <= 1'b0;
      alu_d0_out    <= 8'd0;
      alu_d1_out    <= 8'd0;
      alu_sel_out   <= 3'd0;
      rec_valid_out <= 1'b0;
      rec_sel_out   <= 3'd0;
      rec_res_out   <= 16'd0;
      rec_gt_out    <= 1'b0;
      rec_eq_out    <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      // Status flags are decoded from the next state so they stay registered.
      busy_out      <= (state_next_s != IDLE);
      rec_valid_out <= (state_next_s == EMIT);
      done_out      <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_in) begin
            alu_d0_out  <= a_in;
            alu_d1_out  <= b_in;
            alu_sel_out <= 3'd0;
            cnt_r       <= 4'd0;
          end
        end
        DRIVE: begin
          if (settle_end_s) begin
            rec_sel_out <= alu_sel_out;
            rec_res_out <= alu_res_in;
            rec_gt_out  <= alu_gt_in;
            rec_eq_out  <= alu_eq_in;
            cnt_r       <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        EMIT: begin
          // Select stops at 7 so it is held through DONE and IDLE.
          if (xfer_s && !last_sel_s) begin
            alu_sel_out <= alu_sel_out + 3'd1;
            cnt_r       <= 4'd0;
          end
        end
        DONE: begin
          cnt_r <= 4'd0;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep.sv
// Bench for alu_sweep: two instances (settle 2 and settle 1) checked each cycle
// against a record-schedule model computed from the sweep timing rules.
module tb_alu_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2, ready;
  logic [7:0] a, b;

  logic        busy1, gt1, eq1, v1, rgt1, req1, done1;
  logic [7:0]  d0_1, d1_1;
  logic [2:0]  sel1, rsel1;
  logic [15:0] res1, rres1;
  logic        busy2, gt2, eq2, v2, rgt2, req2, done2;
  logic [7:0]  d0_2, d1_2;
  logic [2:0]  sel2, rsel2;
  logic [15:0] res2, rres2;

  // ALU model attached to each instance
  assign res1 = {5'b0, sel1, d0_1};
  assign gt1  = d0_1 > d1_1;
  assign eq1  = d0_1 == d1_1;
  assign res2 = {5'b0, sel2, d0_2};
  assign gt2  = d0_2 > d1_2;
  assign eq2  = d0_2 == d1_2;

  alu_sweep #(.SETTLE_CYCLES(2)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .a_in(a), .b_in(b),
    .busy_out(busy1), .alu_d0_out(d0_1), .alu_d1_out(d1_1), .alu_sel_out(sel1),
    .alu_res_in(res1), .alu_gt_in(gt1), .alu_eq_in(eq1),
    .rec_valid_out(v1), .rec_ready_in(ready), .rec_sel_out(rsel1),
    .rec_res_out(rres1), .rec_gt_out(rgt1), .rec_eq_out(req1), .done_out(done1));

  alu_sweep #(.SETTLE_CYCLES(1)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .a_in(a), .b_in(b),
    .busy_out(busy2), .alu_d0_out(d0_2), .alu_d1_out(d1_2), .alu_sel_out(sel2),
    .alu_res_in(res2), .alu_gt_in(gt2), .alu_eq_in(eq2),
    .rec_valid_out(v2), .rec_ready_in(ready), .rec_sel_out(rsel2),
    .rec_res_out(rres2), .rec_gt_out(rgt2), .rec_eq_out(req2), .done_out(done2));

  bit use2;
  logic        o_busy, o_valid, o_gt, o_eq, o_done, o_rgt, o_req;
  logic [7:0]  o_d0, o_d1;
  logic [2:0]  o_sel, o_rsel;
  logic [15:0] o_rres;
  assign o_busy  = use2 ? busy2 : busy1;
  assign o_valid = use2 ? v2    : v1;
  assign o_done  = use2 ? done2 : done1;
  assign o_d0    = use2 ? d0_2  : d0_1;
  assign o_d1    = use2 ? d1_2  : d1_1;
  assign o_sel   = use2 ? sel2  : sel1;
  assign o_rsel  = use2 ? rsel2 : rsel1;
  assign o_rres  = use2 ? rres2 : rres1;
  assign o_rgt   = use2 ? rgt2  : rgt1;
  assign o_req   = use2 ? req2  : req1;
  assign o_gt    = use2 ? gt2   : gt1;
  assign o_eq    = use2 ? eq2   : eq1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},  32'(o_busy),  32'd0);
    chk({tag, " valid"}, 32'(o_valid), 32'd0);
    chk({tag, " done"},  32'(o_done),  32'd0);
    chk({tag, " d0"},    32'(o_d0),    32'd0);
    chk({tag, " d1"},    32'(o_d1),    32'd0);
    chk({tag, " sel"},   32'(o_sel),   32'd0);
    chk({tag, " rsel"},  32'(o_rsel),  32'd0);
    chk({tag, " rres"},  32'(o_rres),  32'd0);
    chk({tag, " rgt"},   32'(o_rgt),   32'd0);
    chk({tag, " req"},   32'(o_req),   32'd0);
  endtask

  // One sweep. stall_k/stall_len: hold ready low that many cycles on record
  // stall_k; mid_c: cycle at which a spurious start with a=99 is pulsed;
  // abort_k: assert reset on the first EMIT cycle of that record.
  task automatic sweep(input bit second, input logic [7:0] av, input logic [7:0] bv,
                       input int stall_k, input int stall_len, input int mid_c,
                       input int abort_k);
    int s_set, s[8], e[8], done_c, nrec, k_now;
    logic rdy;
    s_set = second ? 1 : 2;
    s[0] = s_set + 1;
    for (int k = 0; k < 8; k++) begin
      e[k] = s[k] + ((k == stall_k) ? stall_len : 0);
      if (k < 7) s[k+1] = e[k] + s_set + 1;
    end
    done_c = e[7] + 1;
    nrec = 0;
    use2 = second;
    @(negedge clk);
    rst_n = 1'b1; a = av; b = bv; ready = 1'b1;
    if (second) start2 = 1'b1; else start1 = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      a = (c == mid_c) ? 8'd99 : av;
      if (c == mid_c) begin
        if (second) start2 = 1'b1; else start1 = 1'b1;
      end
      k_now = -1;
      for (int k = 0; k < 8; k++) if (c >= s[k] && c <= e[k]) k_now = k;
      chk("valid", 32'(o_valid), 32'(k_now >= 0));
      chk("busy",  32'(o_busy),  32'(c <= done_c));
      chk("done",  32'(o_done),  32'(c == done_c));
      chk("d0",    32'(o_d0),    32'(av));
      chk("d1",    32'(o_d1),    32'(bv));
      if (k_now >= 0) begin
        chk("rsel", 32'(o_rsel), 32'(k_now));
        chk("rres", 32'(o_rres), 32'(k_now * 256 + int'(av)));
        chk("rgt",  32'(o_rgt),  32'(av > bv));
        chk("req",  32'(o_req),  32'(av == bv));
        chk("sel",  32'(o_sel),  32'(k_now));
      end
      if (c == done_c + 1) chk("sel_hold", 32'(o_sel), 32'd7);
      if (abort_k >= 0 && c == s[abort_k]) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        return;
      end
      if (k_now >= 0) rdy = !(k_now == stall_k && c < e[k_now]);
      else            rdy = 1'($urandom);
      ready = rdy;
      if (k_now >= 0 && rdy) nrec++;
    end
    chk("nrec", 32'(nrec), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; ready = 1'b0;
    a = 8'd0; b = 8'd0; use2 = 1'b0;
    repeat (3) @(negedge clk);
    use2 = 1'b0; #1 chk_zero("rst1");
    use2 = 1'b1; #1 chk_zero("rst2");

    sweep(1'b0, 8'd12,  8'd45,  -1, 0, -1, -1);
    sweep(1'b0, 8'd12,  8'd45,   3, 5, -1, -1);
    sweep(1'b0, 8'd12,  8'd45,  -1, 0, 10, -1);
    sweep(1'b0, 8'd12,  8'd45,  -1, 0, -1,  4);
    sweep(1'b0, 8'd12,  8'd45,  -1, 0, -1, -1);
    sweep(1'b0, 8'd200, 8'd200, -1, 0, -1, -1);
    sweep(1'b1, 8'd12,  8'd45,  -1, 0, -1, -1);
    repeat (6) begin
      sweep(1'($urandom), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
